// File: rtl/data_mem_pkg.sv
// Shared definitions for the data memory controller: RV32 load/store width
// codes and the controller state encoding.
package data_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    RSP  = 2'd2
  } state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: request classification, byte enables and store
// lane replication on the request side; lane select and extension on the load side.
module lsu_align
  import data_mem_pkg::*;
(
  input  logic        i_we,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_store_data,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic        o_illegal,
  output logic        o_misaligned,
  input  logic [2:0]  i_rd_funct3,
  input  logic [1:0]  i_rd_lane,
  input  logic [31:0] i_rd_word,
  output logic [31:0] o_load_data
);

  logic [31:0] w_shift;

  always_comb begin
    o_be         = 4'b0000;
    o_wdata      = 32'h0;
    o_illegal    = 1'b0;
    o_misaligned = 1'b0;
    case (i_funct3)
      F3_B: begin
        o_be    = 4'b0001 << i_lane;
        o_wdata = {4{i_store_data[7:0]}};
      end
      F3_H: begin
        o_be         = i_lane[1] ? 4'b1100 : 4'b0011;
        o_wdata      = {2{i_store_data[15:0]}};
        o_misaligned = i_lane[0];
      end
      F3_W: begin
        o_be         = 4'b1111;
        o_wdata      = i_store_data;
        o_misaligned = |i_lane;
      end
      // Unsigned widths exist only for loads
      F3_BU:   o_illegal = i_we;
      F3_HU: begin
        o_illegal    = i_we;
        o_misaligned = i_lane[0];
      end
      default: o_illegal = 1'b1;
    endcase
  end

  assign w_shift = i_rd_word >> {i_rd_lane, 3'b000};

  always_comb begin
    o_load_data = 32'h0;
    case (i_rd_funct3)
      F3_B:    o_load_data = {{24{w_shift[7]}}, w_shift[7:0]};
      F3_H:    o_load_data = {{16{w_shift[15]}}, w_shift[15:0]};
      F3_W:    o_load_data = i_rd_word;
      F3_BU:   o_load_data = {24'h0, w_shift[7:0]};
      F3_HU:   o_load_data = {16'h0, w_shift[15:0]};
      default: o_load_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Word-organised data memory with an RV32 byte/half/word load-store front end,
// power-up clear sequence and a one-deep valid/ready response.
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter int ADDR_W     = 5,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] rs1,
  input  logic [31:0] immediate,
  input  logic [31:0] store_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err
);

  localparam int DEPTH = 2 ** ADDR_W;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_init_idx;
  logic [31:0]       r_mem [DEPTH];
  logic [31:0]       r_rd_word;
  logic              r_rsp_err;
  logic              r_rsp_load;
  logic [2:0]        r_rsp_f3;
  logic [1:0]        r_rsp_lane;

  logic [31:0]       w_ea;
  logic [ADDR_W-1:0] w_idx;
  logic              w_oob;
  logic              w_illegal;
  logic              w_misaligned;
  logic              w_err;
  logic              w_accept;
  logic              w_st;
  logic              w_ld;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic [31:0]       w_load_data;
  logic              w_init_wr;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [3:0]        w_wr_be;
  logic [31:0]       w_wr_data;

  assign w_ea     = rs1 + immediate;
  assign w_idx    = w_ea[ADDR_W+1:2];
  assign w_oob    = |w_ea[31:ADDR_W+2];
  assign w_accept = req_valid && (r_state == IDLE);
  assign w_err    = w_illegal | w_misaligned | w_oob;
  assign w_st     = w_accept & req_we & ~w_err;
  assign w_ld     = w_accept & ~req_we & ~w_err;

  lsu_align u_align (
    .i_we         (req_we),
    .i_funct3     (req_funct3),
    .i_lane       (w_ea[1:0]),
    .i_store_data (store_data),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_illegal    (w_illegal),
    .o_misaligned (w_misaligned),
    .i_rd_funct3  (r_rsp_f3),
    .i_rd_lane    (r_rsp_lane),
    .i_rd_word    (r_rd_word),
    .o_load_data  (w_load_data)
  );

  // Single write port shared by the clear sequence and stores
  assign w_init_wr = (r_state == INIT) && INIT_CLEAR;
  assign w_wr_addr = w_init_wr ? r_init_idx : w_idx;
  assign w_wr_be   = w_init_wr ? 4'b1111 : (w_st ? w_be : 4'b0000);
  assign w_wr_data = w_init_wr ? 32'h0 : w_wdata;

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (w_wr_be[b]) r_mem[w_wr_addr][8*b +: 8] <= w_wr_data[8*b +: 8];
    end
    if (w_ld) r_rd_word <= r_mem[w_idx];
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      INIT:    if (!INIT_CLEAR || (&r_init_idx)) w_state_nxt = IDLE;
      IDLE:    if (req_valid) w_state_nxt = RSP;
      RSP:     if (rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= INIT;
      r_init_idx <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == INIT) r_init_idx <= r_init_idx + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_err  <= 1'b0;
      r_rsp_load <= 1'b0;
      r_rsp_f3   <= 3'b000;
      r_rsp_lane <= 2'b00;
    end else if (w_accept) begin
      r_rsp_err  <= w_err;
      r_rsp_load <= ~req_we & ~w_err;
      r_rsp_f3   <= req_funct3;
      r_rsp_lane <= w_ea[1:0];
    end
  end

  // Outputs decode from state so reset clears them without waiting for a clock
  assign req_ready = (r_state == IDLE);
  assign rsp_valid = (r_state == RSP);
  assign rsp_err   = rsp_valid & r_rsp_err;
  assign rsp_data  = (rsp_valid && r_rsp_load) ? w_load_data : 32'h0;

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, word-address bits; depth = 2**ADDR_W 32-bit words.
REQ-002 SHALL have parameter INIT_CLEAR, default 1, zero-fill the array after reset when 1.
REQ-003 SHALL have port clk  input  1  single clock, all state rising-edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  request accepted this cycle when high with req_valid.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_funct3  input  3  RV32 width/sign code.
REQ-009 SHALL have port rs1  input  32  base address.
REQ-010 SHALL have port immediate  input  32  offset.
REQ-011 SHALL have port store_data  input  32  store value, sub-word data in low bits.
REQ-012 SHALL have port rsp_valid  output  1  response present.
REQ-013 SHALL have port rsp_ready  input  1  consumer takes response.
REQ-014 SHALL have port rsp_data  output  32  extended load data, 0 for stores and errors.
REQ-015 SHALL have port rsp_err  output  1  misaligned, out-of-range or illegal funct3.

Function
REQ-016 SHALL form effective address ea = rs1 + immediate, modulo 2**32; word index = ea[ADDR_W+1:2], lane = ea[1:0].
REQ-017 SHALL implement states INIT, IDLE, RSP; req_ready high only in IDLE.
REQ-018 INIT SHALL write zero to one word per cycle, index 0 upward, then enter IDLE after word 2**ADDR_W-1; with INIT_CLEAR=0 INIT lasts exactly one cycle.
REQ-019 Loads SHALL accept funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores SHALL accept 000 SB, 001 SH, 010 SW; any other code is illegal.
REQ-020 Misaligned SHALL mean halfword with ea[0]=1 or word with ea[1:0]!=0; out-of-range SHALL mean ea[31:ADDR_W+2] != 0.
REQ-021 On acceptance of a legal store, only the addressed byte lanes SHALL be written at that clock edge; other lanes unchanged.
REQ-022 On acceptance of a legal load, the addressed word SHALL be read synchronously at that edge; lane select and sign/zero extension applied to the registered word.
REQ-023 Any erroring request SHALL not modify the array; response rsp_err=1, rsp_data=0.
REQ-024 Latency SHALL be one cycle: acceptance in cycle N gives rsp_valid=1 from cycle N+1.
REQ-025 In RSP, rsp_valid, rsp_data, rsp_err SHALL hold stable until a cycle with rsp_ready=1, then return to IDLE next cycle; throughput max one request per two cycles.
REQ-026 Store response SHALL be rsp_data=0, rsp_err=0 (write acknowledge).
REQ-027 A load to a word stored by the immediately preceding request SHALL return the new data.
REQ-028 req_valid in INIT or RSP SHALL be ignored (not accepted, no side effect).

Reset
REQ-029 rst high SHALL immediately force state INIT, init index 0, req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0.
REQ-030 Reset mid-RSP SHALL drop the pending response; reset mid-INIT SHALL restart the clear from index 0.
REQ-031 Array contents SHALL not be reset asynchronously; only INIT clears them.

Structure
REQ-032 Package data_mem_pkg SHALL hold funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU) and the state enumeration.
REQ-033 Byte-enable generation, store lane shifting and load extension SHALL live in combinational sub-module lsu_align.
REQ-034 Array SHALL be a single 32-bit-wide memory with per-byte write enables, inferable as block RAM.

Verification
REQ-035 Reset then idle -> req_ready low for exactly 32 cycles (ADDR_W=5), then high; LW of any word returns 0.
REQ-036 SW 0xDEADBEEF at rs1=0x10, imm=4 then LW at 0x14 -> rsp_data 0xDEADBEEF, rsp_err 0, rsp_valid one cycle after each acceptance.
REQ-037 After 36, SB 0x7F at 0x15, LB 0x15 -> 0x0000007F; LB 0x17 -> 0xFFFFFFDE; LBU 0x17 -> 0x000000DE; LH 0x16 -> 0xFFFFDEAD; LW 0x14 -> 0xDEAD7FEF.
REQ-038 SW at 0x13, LH at 0x15, LW at 0x80, funct3 011 -> each rsp_err 1, rsp_data 0, word 0x10 unchanged.
REQ-039 LW issued with rsp_ready low for 5 cycles -> response stable all 5 cycles, req_ready low, next request accepted only after rsp_ready pulse.
REQ-040 rst asserted during RSP and during INIT -> rsp_valid falls same cycle, INIT restarts full 32-cycle clear.
